mem_access_ctrl: RTL and testbench

//  Initiator side of the reg_memory port: turns CPU load/store requests into reg_memory

---
 rtl/cpu_mem_pkg.sv | 17 +
 rtl/mem_burst_counter.sv | 53 +++++
 rtl/reg_memory.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-side reg_memory initiator: default widths and
// the controller state encoding.
package cpu_mem_pkg;

   localparam int DEF_REGISTER_WIDTH       = 4;
   localparam int DEF_MEMORY_ADDRESS_WIDTH = 4;
   localparam int DEF_MEMORY_REGISTERS     = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WRITE    = 3'd1,
      ST_RD_ISSUE = 3'd2,
      ST_RD_WAIT  = 3'd3,
      ST_RESP     = 3'd4
   } state_e;

endpackage

// File: rtl/mem_burst_counter.sv
// Burst bookkeeping: current address (wraps at 2**AW) and remaining beat count,
// with a flag marking the final beat of the burst.
module mem_burst_counter
   import cpu_mem_pkg::*;
#(
   parameter int AW = DEF_MEMORY_ADDRESS_WIDTH
)(
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          load_i,
   input  logic          step_i,
   input  logic [AW-1:0] addr_i,
   input  logic [AW-1:0] len_i,
   output logic [AW-1:0] addr_o,
   output logic [AW-1:0] beats_o,
   output logic          last_o
);

   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] beats_q, beats_d;

   // load on request accept, advance one beat per completed transfer
   always_comb begin
      addr_d  = addr_q;
      beats_d = beats_q;
      if (load_i) begin
         addr_d  = addr_i;
         beats_d = len_i;
      end else if (step_i) begin
         addr_d  = addr_q + {{(AW-1){1'b0}}, 1'b1};
         beats_d = beats_q - {{(AW-1){1'b0}}, 1'b1};
      end else begin
         addr_d  = addr_q;
         beats_d = beats_q;
      end
   end

   // counter registers
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         addr_q  <= {AW{1'b0}};
         beats_q <= {AW{1'b0}};
      end else begin
         addr_q  <= addr_d;
         beats_q <= beats_d;
      end
   end

   assign addr_o  = addr_q;
   assign beats_o = beats_q;
   assign last_o  = (beats_q == {AW{1'b0}});

endmodule

// File: rtl/reg_memory.sv
// Register-file memory target: synchronous write, registered read data valid the
// cycle after read_en. Contents are not cleared by reset.
module reg_memory
   import cpu_mem_pkg::*;
#(
   parameter int REGISTER_WIDTH       = DEF_REGISTER_WIDTH,
   parameter int MEMORY_ADDRESS_WIDTH = DEF_MEMORY_ADDRESS_WIDTH,
   parameter int MEMORY_REGISTERS     = DEF_MEMORY_REGISTERS
)(
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic                            write_en_i,
   input  logic                            read_en_i,
   input  logic [MEMORY_ADDRESS_WIDTH-1:0] addr_i,
   input  logic [REGISTER_WIDTH-1:0]       data_i,
   output logic [REGISTER_WIDTH-1:0]       data_o
);

   logic [REGISTER_WIDTH-1:0] regs_q [MEMORY_REGISTERS];
   logic [REGISTER_WIDTH-1:0] data_q;

   // storage array
   always_ff @(posedge clk_i) begin
      if (write_en_i) begin
         regs_q[addr_i] <= data_i;
      end
   end

   // read data register
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         data_q <= {REGISTER_WIDTH{1'b0}};
      end else if (read_en_i) begin
         data_q <= regs_q[addr_i];
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator for the reg_memory port: converts CPU single/burst load/store requests
// into read_en/write_en cycles, with a backpressured read response channel.
module mem_access_ctrl
   import cpu_mem_pkg::*;
#(
   parameter int REGISTER_WIDTH       = DEF_REGISTER_WIDTH,
   parameter int MEMORY_ADDRESS_WIDTH = DEF_MEMORY_ADDRESS_WIDTH,
   parameter int MEMORY_REGISTERS     = DEF_MEMORY_REGISTERS
)(
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic                            req_valid_i,
   output logic                            req_ready_o,
   input  logic                            req_write_i,
   input  logic [MEMORY_ADDRESS_WIDTH-1:0] req_addr_i,
   input  logic [MEMORY_ADDRESS_WIDTH-1:0] req_len_i,
   input  logic                            wdata_valid_i,
   output logic                            wdata_ready_o,
   input  logic [REGISTER_WIDTH-1:0]       wdata_i,
   output logic                            rsp_valid_o,
   input  logic                            rsp_ready_i,
   output logic [REGISTER_WIDTH-1:0]       rsp_data_o,
   output logic [MEMORY_ADDRESS_WIDTH-1:0] rsp_addr_o,
   output logic                            mem_write_en_o,
   output logic                            mem_read_en_o,
   output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
   output logic [REGISTER_WIDTH-1:0]       mem_wdata_o,
   input  logic [REGISTER_WIDTH-1:0]       mem_rdata_i,
   output logic                            busy_o,
   output logic                            done_o
);

   localparam int AW = MEMORY_ADDRESS_WIDTH;
   localparam int RW = REGISTER_WIDTH;

   if (MEMORY_REGISTERS != (1 << MEMORY_ADDRESS_WIDTH)) begin : g_cfg_check
      $error("MEMORY_REGISTERS must equal 2**MEMORY_ADDRESS_WIDTH");
   end

   state_e        state_q, state_d;
   logic          done_q, done_d;
   logic [RW-1:0] rsp_data_q, rsp_data_d;
   logic [AW-1:0] rsp_addr_q, rsp_addr_d;

   logic          req_acc_s, wbeat_s, rsp_acc_s, last_s;
   logic [AW-1:0] addr_s, beats_s;

   assign req_acc_s = (state_q == ST_IDLE)  && req_valid_i;
   assign wbeat_s   = (state_q == ST_WRITE) && wdata_valid_i;
   assign rsp_acc_s = (state_q == ST_RESP)  && rsp_ready_i;

   mem_burst_counter #(.AW(AW)) u_burst_counter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .load_i  (req_acc_s),
      .step_i  ((wbeat_s || rsp_acc_s) && !last_s),
      .addr_i  (req_addr_i),
      .len_i   (req_len_i),
      .addr_o  (addr_s),
      .beats_o (beats_s),
      .last_o  (last_s)
   );

   // state and response registers
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= ST_IDLE;
         done_q     <= 1'b0;
         rsp_data_q <= {RW{1'b0}};
         rsp_addr_q <= {AW{1'b0}};
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         rsp_data_q <= rsp_data_d;
         rsp_addr_q <= rsp_addr_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               state_d = req_write_i ? ST_WRITE : ST_RD_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (wbeat_s && last_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_RD_ISSUE: state_d = ST_RD_WAIT;
         ST_RD_WAIT:  state_d = ST_RESP;
         ST_RESP: begin
            if (rsp_acc_s) begin
               state_d = last_s ? ST_IDLE : ST_RD_ISSUE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // handshakes and memory strobes decoded from the current state
   always_comb begin
      req_ready_o    = 1'b0;
      wdata_ready_o  = 1'b0;
      mem_write_en_o = 1'b0;
      mem_read_en_o  = 1'b0;
      rsp_valid_o    = 1'b0;
      busy_o         = 1'b1;
      case (state_q)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
         end
         ST_WRITE: begin
            wdata_ready_o  = 1'b1;
            mem_write_en_o = wdata_valid_i;
         end
         ST_RD_ISSUE: mem_read_en_o = 1'b1;
         ST_RD_WAIT:  busy_o        = 1'b1;
         ST_RESP:     rsp_valid_o   = 1'b1;
         default:     busy_o        = 1'b0;
      endcase
   end

   // memory data is only valid the cycle after read_en, i.e. in RD_WAIT
   always_comb begin
      done_d = (wbeat_s || rsp_acc_s) && last_s;
      if (state_q == ST_RD_WAIT) begin
         rsp_data_d = mem_rdata_i;
         rsp_addr_d = addr_s;
      end else begin
         rsp_data_d = rsp_data_q;
         rsp_addr_d = rsp_addr_q;
      end
   end

   assign mem_addr_o  = addr_s;
   assign mem_wdata_o = wdata_i;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_addr_o  = rsp_addr_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl driving a real reg_memory: a reference
// memory array predicts read responses, a monitor checks them and the protocol.
module tb_mem_access_ctrl;
   import cpu_mem_pkg::*;

   localparam int AW = 4;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          req_valid_i, req_ready_o, req_write_i;
   logic [AW-1:0] req_addr_i, req_len_i;
   logic          wdata_valid_i, wdata_ready_o;
   logic [RW-1:0] wdata_i;
   logic          rsp_valid_o, rsp_ready_i;
   logic [RW-1:0] rsp_data_o;
   logic [AW-1:0] rsp_addr_o;
   logic          mem_write_en_o, mem_read_en_o;
   logic [AW-1:0] mem_addr_o;
   logic [RW-1:0] mem_wdata_o, mem_rdata_i;
   logic          busy_o, done_o;

   always #5 clk = ~clk;

   mem_access_ctrl #(.REGISTER_WIDTH(RW), .MEMORY_ADDRESS_WIDTH(AW), .MEMORY_REGISTERS(16)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
      .req_addr_i(req_addr_i), .req_len_i(req_len_i),
      .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_addr_o(rsp_addr_o),
      .mem_write_en_o(mem_write_en_o), .mem_read_en_o(mem_read_en_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .done_o(done_o)
   );

   reg_memory #(.REGISTER_WIDTH(RW), .MEMORY_ADDRESS_WIDTH(AW), .MEMORY_REGISTERS(16)) u_mem (
      .clk_i(clk), .reset_i(reset_i),
      .write_en_i(mem_write_en_o), .read_en_i(mem_read_en_o),
      .addr_i(mem_addr_o), .data_i(mem_wdata_o), .data_o(mem_rdata_i)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [RW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   logic [RW-1:0] model_mem [16];
   int            tests = 0, fails = 0, cyc = 0;
   int            done_seen = 0, done_exp = 0, wr_seen = 0, wr_exp = 0;
   int            rd_issued = 0, rsp_acc = 0, rd_issue_cyc = 0;
   int            rdy_mode = 2;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // response-ready driver: 0 random, 1 held low, 2 held high
   initial begin
      rsp_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       rsp_ready_i = ($urandom_range(0, 3) != 0);
            1:       rsp_ready_i = 1'b0;
            default: rsp_ready_i = 1'b1;
         endcase
      end
   end

   // monitor: protocol checks and scoreboard pops, sampled on the falling edge
   initial begin
      logic          prev_valid, prev_acc;
      logic [RW-1:0] prev_data;
      logic [AW-1:0] prev_addr;
      exp_t          e;
      prev_valid = 1'b0; prev_acc = 1'b0; prev_data = '0; prev_addr = '0;
      forever begin
         @(negedge clk);
         if (reset_i !== 1'b1) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
            rsp_acc    = rd_issued;
         end else begin
            if (mem_read_en_o) begin
               check("rd_wr_exclusive", 32'(mem_write_en_o), 32'd0);
               check("single_outstanding", 32'(rd_issued - rsp_acc), 32'd0);
               rd_issued++;
               rd_issue_cyc = cyc;
            end
            if (mem_write_en_o) wr_seen++;
            if (done_o) done_seen++;
            if (rsp_valid_o && !prev_valid)
               check("rd_latency", 32'(cyc - rd_issue_cyc), 32'd2);
            if (rsp_valid_o && prev_valid && !prev_acc) begin
               check("rsp_data_stable", 32'(rsp_data_o), 32'(prev_data));
               check("rsp_addr_stable", 32'(rsp_addr_o), 32'(prev_addr));
            end
            if (rsp_valid_o && rsp_ready_i) begin
               check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("rsp_data", 32'(rsp_data_o), 32'(e.data));
                  check("rsp_addr", 32'(rsp_addr_o), 32'(e.addr));
               end
               rsp_acc++;
            end
            prev_valid = rsp_valid_o;
            prev_acc   = rsp_valid_o && rsp_ready_i;
            prev_data  = rsp_data_o;
            prev_addr  = rsp_addr_o;
         end
      end
   end

   task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [AW-1:0] len);
      @(posedge clk); #1;
      req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_len_i = len;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      check("req_accepted", 32'(busy_o), 32'd1);
   endtask

   // fixed_base >= 0 gives data fixed_base+i; abort_after >= 0 resets before that beat
   task automatic wr_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len, input int gap,
                           input bit hold_req, input int abort_after, input int fixed_base);
      logic [RW-1:0] d;
      logic [AW-1:0] a;
      issue(1'b1, addr, len);
      if (hold_req) begin
         req_valid_i = 1'b1; req_write_i = 1'b0;
      end
      for (int i = 0; i <= int'(len); i++) begin
         d = (fixed_base >= 0) ? RW'(fixed_base + i) : RW'($urandom);
         a = addr + AW'(i);
         if (i == abort_after) begin
            wdata_valid_i = 1'b1; wdata_i = d; reset_i = 1'b0;
            #1;
            check("abort_write_en", 32'(mem_write_en_o), 32'd0);
            check("abort_read_en", 32'(mem_read_en_o), 32'd0);
            check("abort_busy", 32'(busy_o), 32'd0);
            check("abort_req_ready", 32'(req_ready_o), 32'd1);
            repeat (2) @(posedge clk);
            #1;
            wdata_valid_i = 1'b0; reset_i = 1'b1;
            return;
         end
         repeat (gap) begin
            wdata_valid_i = 1'b0; wdata_i = ~d;
            @(posedge clk); #1;
            if (hold_req) check("req_blocked", 32'(req_ready_o), 32'd0);
         end
         wdata_valid_i = 1'b1; wdata_i = d;
         @(posedge clk); #1;
         model_mem[a] = d;
         wr_exp++;
      end
      wdata_valid_i = 1'b0;
      req_valid_i   = 1'b0;
      done_exp++;
   endtask

   task automatic rd_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len);
      exp_t          e;
      for (int i = 0; i <= int'(len); i++) begin
         e.addr = addr + AW'(i);
         e.data = model_mem[e.addr];
         exp_q.push_back(e);
      end
      issue(1'b0, addr, len);
      done_exp++;
   endtask

   task automatic finish_req();
      int n = 0;
      while ((busy_o || exp_q.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", 32'(busy_o), 32'd0);
      repeat (2) @(negedge clk);
      check("done_count", 32'(done_seen), 32'(done_exp));
      check("write_count", 32'(wr_seen), 32'(wr_exp));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      reset_i = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_len_i = '0;
      wdata_valid_i = 1'b0; wdata_i = '0;
      for (int i = 0; i < 16; i++) model_mem[i] = '0;

      // reset state
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_req_ready", 32'(req_ready_o), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_write_en", 32'(mem_write_en_o), 32'd0);
      check("rst_read_en", 32'(mem_read_en_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_rsp_data", 32'(rsp_data_o), 32'd0);
      check("rst_rsp_addr", 32'(rsp_addr_o), 32'd0);
      @(posedge clk); #1;
      reset_i = 1'b1;

      // full-memory fill, maximum burst length
      wr_burst(4'd0, 4'd15, 0, 1'b0, -1, -1);
      finish_req();

      // single write then single read
      wr_burst(4'd3, 4'd0, 0, 1'b0, -1, 10);
      finish_req();
      rd_burst(4'd3, 4'd0);
      finish_req();

      // wrapping bursts
      wr_burst(4'd14, 4'd3, 0, 1'b0, -1, 1);
      finish_req();
      rdy_mode = 0;
      rd_burst(4'd14, 4'd3);
      finish_req();

      // response backpressure
      rdy_mode = 1;
      rd_burst(4'd5, 4'd1);
      n = 0;
      while (!rsp_valid_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      repeat (5) begin
         @(negedge clk);
         check("bp_no_second_read", 32'(mem_read_en_o), 32'd0);
      end
      rdy_mode = 2;
      finish_req();

      // write stalls with a competing request held high
      wr_burst(4'd8, 4'd3, 2, 1'b1, -1, -1);
      finish_req();

      // randomized traffic
      rdy_mode = 0;
      for (int k = 0; k < 24; k++) begin
         logic [AW-1:0] a, l;
         a = AW'($urandom);
         l = ($urandom_range(0, 7) == 0) ? 4'd15 : AW'($urandom_range(0, 4));
         if ($urandom_range(0, 1) == 1) wr_burst(a, l, $urandom_range(0, 2), 1'b0, -1, -1);
         else rd_burst(a, l);
         finish_req();
      end

      // reset in the middle of a write burst
      rdy_mode = 2;
      wr_burst(4'd5, 4'd3, 0, 1'b0, 2, -1);
      finish_req();
      rd_burst(4'd5, 4'd3);
      finish_req();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
